// File: rtl/rgb_capture.sv
// RGB video capture: samples the 24-bit parallel bus, packs active pixels into RAM words and
// writes whole frames into a ring of frame slots, tracking completed frames.
module rgb_capture #(
    parameter int unsigned RAM_ADDR_WIDTH       = 32,
    parameter int unsigned RAM_DATA_WIDTH       = 16,
    parameter int unsigned IMAGE_WIDTH          = 40,
    parameter int unsigned IMAGE_HEIGHT         = 48,
    parameter int unsigned IMAGE_IN_RAM         = 18,
    parameter int unsigned SLICES_BEFORE_STREAM = 1,
    parameter int unsigned PIXEL_FORMAT         = 0
) (
    input  logic                                rgb_clk,
    input  logic                                nrst,
    input  logic [23:0]                         rgb,
    input  logic                                hsync,
    input  logic                                vsync,
    input  logic                                rgb_enable,
    input  logic                                ring_mode,
    output logic [RAM_ADDR_WIDTH-1:0]           ram_addr,
    output logic [RAM_DATA_WIDTH-1:0]           ram_data,
    output logic                                write_enable,
    output logic                                stream_ready,
    output logic [$clog2(IMAGE_IN_RAM+1)-1:0]   frame_count,
    output logic                                frame_error
);

    localparam int unsigned ImageSize = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned FcW       = $clog2(IMAGE_IN_RAM + 1);

    localparam logic [RAM_ADDR_WIDTH-1:0] ImgSize  = RAM_ADDR_WIDTH'(ImageSize);
    localparam logic [RAM_ADDR_WIDTH-1:0] LastBase =
        RAM_ADDR_WIDTH'(ImageSize * (IMAGE_IN_RAM - 1));
    localparam logic [FcW-1:0] FcMax    = FcW'(IMAGE_IN_RAM);
    localparam logic [FcW-1:0] FcStream = FcW'(SLICES_BEFORE_STREAM);

    typedef enum logic [1:0] {StIdle, StSync, StCapture, StFull} state_e;

    state_e                    r_state;
    logic                      r_vsync;
    logic                      r_ring;
    logic [RAM_ADDR_WIDTH-1:0] r_base;
    logic [RAM_ADDR_WIDTH-1:0] r_cnt;

    logic                      w_active;
    logic                      w_vs_rise;
    logic                      w_vs_fall;
    logic [FcW-1:0]            w_fc_next;
    logic [15:0]               w_pix16;
    logic                      w_unused_rgb;

    assign w_active     = hsync & vsync;
    assign w_vs_rise    = vsync & ~r_vsync;
    assign w_vs_fall    = ~vsync & r_vsync;
    assign w_fc_next    = (frame_count == FcMax) ? frame_count : frame_count + 1'b1;
    // Low colour bits are discarded by every packing format.
    assign w_unused_rgb = ^rgb;

    always_comb begin
        case (PIXEL_FORMAT)
            1:       w_pix16 = {1'b0, rgb[23:19], rgb[15:11], rgb[7:3]};
            2:       w_pix16 = {4'b0, rgb[23:20], rgb[15:12], rgb[7:4]};
            default: w_pix16 = {rgb[23:19], rgb[15:10], rgb[7:3]};
        endcase
    end

    always_ff @(posedge rgb_clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= StIdle;
            r_vsync      <= 1'b0;
            r_ring       <= 1'b0;
            r_base       <= '0;
            r_cnt        <= '0;
            ram_addr     <= '0;
            ram_data     <= '0;
            write_enable <= 1'b0;
            stream_ready <= 1'b0;
            frame_count  <= '0;
            frame_error  <= 1'b0;
        end else begin
            r_vsync      <= vsync;
            write_enable <= 1'b0;
            frame_error  <= 1'b0;
            // Disable beats everything, including a frame completing in the same cycle.
            if (!rgb_enable) begin
                r_state      <= StIdle;
                r_base       <= '0;
                r_cnt        <= '0;
                ram_addr     <= '0;
                ram_data     <= '0;
                stream_ready <= 1'b0;
                frame_count  <= '0;
            end else begin
                unique case (r_state)
                    StIdle: r_state <= StSync;
                    StSync: begin
                        if (w_vs_rise) begin
                            r_state  <= StCapture;
                            r_cnt    <= '0;
                            r_ring   <= ring_mode;
                            ram_addr <= r_base;
                        end
                    end
                    StCapture: begin
                        if (w_vs_fall) begin
                            if (r_cnt == ImgSize) begin
                                frame_count <= w_fc_next;
                                if (w_fc_next >= FcStream) stream_ready <= 1'b1;
                                if (r_base == LastBase) begin
                                    r_base  <= '0;
                                    r_state <= r_ring ? StSync : StFull;
                                end else begin
                                    r_base  <= r_base + ImgSize;
                                    r_state <= StSync;
                                end
                            end else begin
                                frame_error <= 1'b1;
                                r_state     <= StSync;
                            end
                        end else if (w_active && r_cnt != ImgSize) begin
                            write_enable <= 1'b1;
                            ram_addr     <= r_base + r_cnt;
                            ram_data     <= RAM_DATA_WIDTH'(w_pix16);
                            r_cnt        <= r_cnt + 1'b1;
                        end
                    end
                    StFull: r_state <= StFull;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_capture.sv
// Scoreboard bench for rgb_capture on a 4x2 image with three frame slots and RGB565 packing.
module tb_rgb_capture;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int SLOTS = 3;
    localparam int SIZE  = W * H;

    logic        rgb_clk = 1'b0;
    logic        nrst;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        rgb_enable;
    logic        ring_mode;
    logic [31:0] ram_addr;
    logic [15:0] ram_data;
    logic        write_enable;
    logic        stream_ready;
    logic [1:0]  frame_count;
    logic        frame_error;

    always #5 rgb_clk = ~rgb_clk;

    rgb_capture #(
        .RAM_ADDR_WIDTH      (32),
        .RAM_DATA_WIDTH      (16),
        .IMAGE_WIDTH         (W),
        .IMAGE_HEIGHT        (H),
        .IMAGE_IN_RAM        (SLOTS),
        .SLICES_BEFORE_STREAM(1),
        .PIXEL_FORMAT        (0)
    ) dut (
        .rgb_clk     (rgb_clk),
        .nrst        (nrst),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb_enable  (rgb_enable),
        .ring_mode   (ring_mode),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .write_enable(write_enable),
        .stream_ready(stream_ready),
        .frame_count (frame_count),
        .frame_error (frame_error)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec    = 0;
    int  n_bad    = 0;
    int  err_seen = 0;
    int  err_exp  = 0;

    // Reference model state: enable seen, slot being filled, completed frames, ring full
    bit  m_en, m_full, m_sr, m_cap, m_ring;
    int  m_fc, m_slot;

    function automatic logic [15:0] pack(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_data"}, ram_data, 0);
        check({tag, "_write_enable"}, write_enable, 0);
        check({tag, "_stream_ready"}, stream_ready, 0);
        check({tag, "_frame_count"}, frame_count, 0);
    endtask

    task automatic model_clear();
        m_fc   = 0;
        m_slot = 0;
        m_full = 0;
        m_sr   = 0;
    endtask

    // Monitor: every write must match the oldest expected word.
    always @(posedge rgb_clk) begin
        wr_t e;
        #1;
        if (frame_error) err_seen++;
        if (write_enable) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write",
                         ram_addr, ram_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", ram_addr, e.addr);
                check("wr_data", ram_data, e.data);
            end
        end
    end

    // One frame of npix active pixels; kind at pixel cut_at: 1 drop enable, 2 reset, 3 enable.
    task automatic frame(input int npix, input int cut_at, input int kind);
        logic [23:0] px;
        wr_t         e;
        int          short_err;
        m_cap = m_en && !m_full;
        if (m_cap) m_ring = ring_mode;
        @(negedge rgb_clk);
        vsync = 1'b1;
        hsync = 1'b0;
        @(negedge rgb_clk);
        for (int i = 0; i < npix; i++) begin
            @(negedge rgb_clk);
            if (i == cut_at) begin
                hsync = 1'b0;
                if (kind == 1) begin
                    rgb_enable = 1'b0;
                    m_en = 0;
                    m_cap = 0;
                    model_clear();
                    @(negedge rgb_clk);
                    check_idle("drop_en");
                end else if (kind == 2) begin
                    nrst = 1'b0;
                    m_cap = 0;
                    model_clear();
                    #1 check_idle("mid_reset");
                    @(negedge rgb_clk);
                    nrst = 1'b1;
                end else if (kind == 3) begin
                    rgb_enable = 1'b1;
                    m_en = 1;
                    @(negedge rgb_clk);
                end
            end
            px    = 24'($urandom);
            rgb   = px;
            hsync = 1'b1;
            if (m_cap && i < SIZE) begin
                e.addr = 32'(m_slot * SIZE + i);
                e.data = pack(px);
                exp_q.push_back(e);
            end
            if (i % W == W - 1 && i != npix - 1) begin
                @(negedge rgb_clk);
                hsync = 1'b0;
            end
        end
        @(negedge rgb_clk);
        hsync = 1'b0;
        vsync = 1'b0;
        short_err = (m_cap && npix < SIZE) ? 1 : 0;
        if (m_cap) begin
            if (npix >= SIZE) begin
                if (m_fc < SLOTS) m_fc++;
                if (m_fc >= 1) m_sr = 1;
                if (m_slot == SLOTS - 1) begin
                    if (m_ring) m_slot = 0;
                    else m_full = 1;
                end else begin
                    m_slot++;
                end
            end else begin
                err_exp++;
            end
        end
        @(negedge rgb_clk);
        check("frame_error", frame_error, short_err);
        check("frame_count", frame_count, m_fc);
        check("stream_ready", stream_ready, m_sr);
        @(negedge rgb_clk);
    endtask

    task automatic restart(input bit ring);
        @(negedge rgb_clk);
        rgb_enable = 1'b0;
        m_en = 0;
        model_clear();
        repeat (2) @(negedge rgb_clk);
        ring_mode  = ring;
        rgb_enable = 1'b1;
        m_en = 1;
        repeat (2) @(negedge rgb_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst       = 1'b0;
        rgb        = '0;
        hsync      = 1'b0;
        vsync      = 1'b0;
        rgb_enable = 1'b0;
        ring_mode  = 1'b0;
        m_en       = 0;
        m_cap      = 0;
        m_ring     = 0;
        model_clear();
        repeat (2) @(negedge rgb_clk);
        check_idle("reset");
        check("reset_frame_error", frame_error, 0);
        nrst = 1'b1;

        frame(8, -1, 0);                    // disabled: nothing written
        restart(0);
        frame(8, -1, 0);
        frame(8, -1, 0);

        @(negedge rgb_clk);                 // enable arrives mid-frame
        rgb_enable = 1'b0;
        m_en = 0;
        model_clear();
        repeat (3) @(negedge rgb_clk);
        frame(8, 3, 3);
        frame(8, -1, 0);

        restart(0);                         // short then full frame
        frame(5, -1, 0);
        frame(8, -1, 0);

        restart(0);                         // long frame
        frame(11, -1, 0);

        restart(0);                         // fill ring, stop
        repeat (4) frame(8, -1, 0);
        restart(1);                         // fill ring, wrap
        repeat (4) frame(8, -1, 0);

        restart(0);                         // drop enable mid-frame
        frame(8, -1, 0);
        frame(8, 4, 1);
        restart(0);                         // reset mid-frame
        frame(8, -1, 0);
        frame(8, 5, 2);
        frame(8, -1, 0);

        restart(0);
        repeat (30) begin
            if ($urandom_range(0, 7) == 0) begin
                restart(1'($urandom_range(0, 1)));
            end else begin
                @(negedge rgb_clk);
                ring_mode = 1'($urandom_range(0, 1));
            end
            frame($urandom_range(3, 12), -1, 0);
        end

        repeat (5) @(negedge rgb_clk);
        check("pending_writes", exp_q.size(), 0);
        check("frame_error_total", err_seen, err_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
